// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for a VGA output.
// A prescaler divides CLK down to the pixel rate; horizontal and vertical
// counters then walk the raster. Coordinates, sync, blanking and frame
// strobes are all decoded from the same registered state, so every output
// describes the same pixel in the same cycle.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        CLK,
  input  logic        RESETn,        // active-high synchronous reset despite the name
  output logic [10:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oPix_En,
  output logic        oFrame_End,
  output logic [7:0]  oFrame_Cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sized decode constants so every comparison is 11 bits wide.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Prescaler is 4 bits wide so it covers the full 1..8 divide range.
  localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);

  // Reject configurations the 11-bit counters or 4-bit prescaler cannot hold.
  generate
    if (H_TOTAL > 2047) begin : g_bad_h_total
      $error("vga_sync_gen: H_TOTAL exceeds 11-bit counter range");
    end
    if (V_TOTAL > 2047) begin : g_bad_v_total
      $error("vga_sync_gen: V_TOTAL exceeds 11-bit counter range");
    end
    if ((CLK_DIV < 1) || (CLK_DIV > 8)) begin : g_bad_clk_div
      $error("vga_sync_gen: CLK_DIV must be in 1..8");
    end
  endgenerate

  logic [3:0]  r_div;
  logic [10:0] r_h;
  logic [10:0] r_v;
  logic [7:0]  r_frame_cnt;

  logic        w_pix_tick;
  logic        w_h_last;
  logic        w_v_last;

  // With CLK_DIV=1 DIV_LAST is 0 and the prescaler never leaves 0, so the
  // tick is asserted on every cycle.
  assign w_pix_tick = (r_div == DIV_LAST);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);

  // Prescaler and raster counters; reset wins immediately, mid-frame or not.
  always_ff @(posedge CLK) begin
    if (RESETn) begin
      r_div       <= 4'd0;
      r_h         <= 11'd0;
      r_v         <= 11'd0;
      r_frame_cnt <= 8'd0;
    end else if (w_pix_tick) begin
      r_div <= 4'd0;
      if (w_h_last) begin
        r_h <= 11'd0;
        if (w_v_last) begin
          r_v         <= 11'd0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_v <= r_v + 11'd1;
        end
      end else begin
        r_h <= r_h + 11'd1;
      end
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  // Output decode purely from registered state: no input-to-output path.
  always_comb begin
    oCoord_X     = r_h;
    oCoord_Y     = r_v;
    oVGA_HS      = !((r_h >= HS_FIRST) && (r_h <= HS_LAST));
    oVGA_VS      = !((r_v >= VS_FIRST) && (r_v <= VS_LAST));
    oVGA_BLANK_N = (r_h < H_VIS_END) && (r_v < V_VIS_END);
    oPix_En      = w_pix_tick;
    oFrame_End   = w_pix_tick && w_h_last && w_v_last;
    oFrame_Cnt   = r_frame_cnt;
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Two instances share one clock and reset: one
// with CLK_DIV=2, one with CLK_DIV=1. Both use a shrunken raster so that
// whole frames (and a 256-frame counter wrap) fit in a short run. Expected
// outputs come from the elapsed cycle count since reset, using plain
// division/modulo over the raster geometry.
module tb_vga_sync_gen;

  // Shrunken raster: H_TOTAL=12, V_TOTAL=9.
  localparam int HV  = 6;
  localparam int HF  = 2;
  localparam int HSY = 2;
  localparam int HB  = 2;
  localparam int VV  = 5;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 1;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int DA  = 2;
  localparam int DB  = 1;
  localparam int FRAME_A = HT * VT * DA;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        pe;
    logic        fe;
    logic [7:0]  fc;
  } vsnap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] ax, ay, bx, by;
  logic        ahs, avs, abl, ape, afe;
  logic        bhs, bvs, bbl, bpe, bfe;
  logic [7:0]  afc, bfc;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;   // cycles since the last reset edge

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(DA), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut_a (
    .CLK(clk), .RESETn(rst),
    .oCoord_X(ax), .oCoord_Y(ay), .oVGA_HS(ahs), .oVGA_VS(avs),
    .oVGA_BLANK_N(abl), .oPix_En(ape), .oFrame_End(afe), .oFrame_Cnt(afc)
  );

  vga_sync_gen #(
    .CLK_DIV(DB), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut_b (
    .CLK(clk), .RESETn(rst),
    .oCoord_X(bx), .oCoord_Y(by), .oVGA_HS(bhs), .oVGA_VS(bvs),
    .oVGA_BLANK_N(bbl), .oPix_En(bpe), .oFrame_End(bfe), .oFrame_Cnt(bfc)
  );

  // Reference: where the raster should be after tc cycles of free running.
  function automatic vsnap_t model(input int d, input int tc);
    vsnap_t s;
    int p, h, v;
    p    = tc / d;
    h    = p % HT;
    v    = (p / HT) % VT;
    s.x  = 11'(h);
    s.y  = 11'(v);
    s.hs = !((h >= HV + HF) && (h < HV + HF + HSY));
    s.vs = !((v >= VV + VF) && (v < VV + VF + VSY));
    s.bl = (h < HV) && (v < VV);
    s.pe = ((tc % d) == d - 1);
    s.fe = s.pe && (h == HT - 1) && (v == VT - 1);
    s.fc = 8'((tc / (d * HT * VT)) % 256);
    return s;
  endfunction

  function automatic vsnap_t obs_a();
    return '{x: ax, y: ay, hs: ahs, vs: avs, bl: abl, pe: ape, fe: afe, fc: afc};
  endfunction

  function automatic vsnap_t obs_b();
    return '{x: bx, y: by, hs: bhs, vs: bvs, bl: bbl, pe: bpe, fe: bfe, fc: bfc};
  endfunction

  // One clock: drive reset, advance the cycle count, land on the falling edge.
  task automatic tick(input logic r);
    rst = r;
    @(posedge clk);
    if (r) t = 0;
    else   t = t + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vsnap_t ra, rb;
    ra = '{x: 11'd0, y: 11'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1, pe: 1'b0, fe: 1'b0, fc: 8'd0};
    rb = ra;
    rb.pe = 1'b1;
    repeat (3) tick(1'b1);
    n_checks++;
    if (obs_a() !== ra) begin
      n_fail++;
      $display("FAIL reset_state_div2 got=%h exp=%h", obs_a(), ra);
    end
    n_checks++;
    if (obs_b() !== rb) begin
      n_fail++;
      $display("FAIL reset_state_div1 got=%h exp=%h", obs_b(), rb);
    end
    tick(1'b0);
    n_checks++;
    if (ax !== 11'd0 || ape !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_c1 x=%0d pe=%b exp x=0 pe=1", ax, ape);
    end
    tick(1'b0);
    n_checks++;
    if (ax !== 11'd1) begin
      n_fail++;
      $display("FAIL reset_release_c2 x=%0d exp 1", ax);
    end
    tick(1'b0);
    tick(1'b0);
    n_checks++;
    if (ax !== 11'd2) begin
      n_fail++;
      $display("FAIL reset_release_c4 x=%0d exp 2", ax);
    end
    $display("test_reset done t=%0d", t);
  endtask

  task automatic test_horizontal();
    int hs_low, bl_low;
    hs_low = 0;
    bl_low = 0;
    tick(1'b1);
    for (int i = 0; i < 2 * HT * DA + 4; i++) begin
      tick(1'b0);
      n_checks++;
      if (obs_a() !== model(DA, t)) begin
        n_fail++;
        $display("FAIL horiz_div2 t=%0d got=%h exp=%h", t, obs_a(), model(DA, t));
      end
      n_checks++;
      if (obs_b() !== model(DB, t)) begin
        n_fail++;
        $display("FAIL horiz_div1 t=%0d got=%h exp=%h", t, obs_b(), model(DB, t));
      end
      if (t < HT * DA) begin
        if (!ahs) hs_low++;
        if (!abl) bl_low++;
      end
      if (t == HT * DA) begin
        n_checks++;
        if (ax !== 11'd0 || ay !== 11'd1) begin
          n_fail++;
          $display("FAIL horiz_line_wrap x=%0d y=%0d exp x=0 y=1", ax, ay);
        end
      end
    end
    n_checks++;
    if (hs_low != HSY * DA) begin
      n_fail++;
      $display("FAIL horiz_hs_width got=%0d exp=%0d", hs_low, HSY * DA);
    end
    n_checks++;
    if (bl_low != (HT - HV) * DA) begin
      n_fail++;
      $display("FAIL horiz_blank_width got=%0d exp=%0d", bl_low, (HT - HV) * DA);
    end
    $display("test_horizontal done hs_low=%0d blank_low=%0d", hs_low, bl_low);
  endtask

  task automatic test_vertical();
    int vs_low, bl_low;
    vs_low = 0;
    bl_low = 0;
    tick(1'b1);
    for (int i = 0; i < FRAME_A + HT * DA; i++) begin
      tick(1'b0);
      n_checks++;
      if (obs_a() !== model(DA, t)) begin
        n_fail++;
        $display("FAIL vert_div2 t=%0d got=%h exp=%h", t, obs_a(), model(DA, t));
      end
      if (t < FRAME_A) begin
        if (!avs) vs_low++;
        if (!abl) bl_low++;
      end
      if (t == FRAME_A) begin
        n_checks++;
        if (ax !== 11'd0 || ay !== 11'd0 || afc !== 8'd1) begin
          n_fail++;
          $display("FAIL vert_frame_wrap x=%0d y=%0d fc=%0d exp 0 0 1", ax, ay, afc);
        end
      end
    end
    n_checks++;
    if (vs_low != VSY * HT * DA) begin
      n_fail++;
      $display("FAIL vert_vs_width got=%0d exp=%0d", vs_low, VSY * HT * DA);
    end
    n_checks++;
    if (bl_low != (HT * VT - HV * VV) * DA) begin
      n_fail++;
      $display("FAIL vert_blank_count got=%0d exp=%0d", bl_low, (HT * VT - HV * VV) * DA);
    end
    $display("test_vertical done vs_low=%0d blank_low=%0d", vs_low, bl_low);
  endtask

  task automatic test_frame_counter();
    int last_fe, pulses;
    logic [7:0] prev_fc;
    bit saw_wrap;
    last_fe  = -1;
    pulses   = 0;
    saw_wrap = 0;
    tick(1'b1);
    prev_fc = afc;
    for (int i = 0; i < 257 * FRAME_A + 4; i++) begin
      tick(1'b0);
      n_checks++;
      if (obs_a() !== model(DA, t)) begin
        n_fail++;
        $display("FAIL frame_div2 t=%0d got=%h exp=%h", t, obs_a(), model(DA, t));
      end
      n_checks++;
      if (obs_b() !== model(DB, t)) begin
        n_fail++;
        $display("FAIL frame_div1 t=%0d got=%h exp=%h", t, obs_b(), model(DB, t));
      end
      if (afe === 1'b1) begin
        pulses++;
        if (last_fe >= 0) begin
          n_checks++;
          if (t - last_fe != FRAME_A) begin
            n_fail++;
            $display("FAIL frame_end_period got=%0d exp=%0d", t - last_fe, FRAME_A);
          end
        end
        last_fe = t;
      end
      if (afc !== prev_fc) begin
        n_checks++;
        if (afc !== prev_fc + 8'd1) begin
          n_fail++;
          $display("FAIL frame_cnt_step got=%0d after=%0d", afc, prev_fc);
        end
        if (prev_fc == 8'd255 && afc == 8'd0) saw_wrap = 1;
        prev_fc = afc;
      end
    end
    n_checks++;
    if (pulses != 257) begin
      n_fail++;
      $display("FAIL frame_end_pulses got=%0d exp=257", pulses);
    end
    n_checks++;
    if (!saw_wrap || afc !== 8'd1) begin
      n_fail++;
      $display("FAIL frame_cnt_wrap wrap_seen=%0d fc=%0d exp wrap and fc=1", saw_wrap, afc);
    end
    $display("test_frame_counter done pulses=%0d fc=%0d", pulses, afc);
  endtask

  task automatic test_mid_reset();
    vsnap_t ra;
    bit found;
    ra = '{x: 11'd0, y: 11'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1, pe: 1'b0, fe: 1'b0, fc: 8'd0};
    found = 0;
    tick(1'b1);
    for (int i = 0; i < 2 * FRAME_A && !found; i++) begin
      tick(1'b0);
      if (ax == 11'(HT - 3) && ay == 11'(VT - 2) && afc != 8'd0) found = 1;
    end
    n_checks++;
    if (!found || ahs !== 1'b0 || avs !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_setup found=%0d hs=%b vs=%b exp found, both low", found, ahs, avs);
    end
    tick(1'b1);
    n_checks++;
    if (obs_a() !== ra) begin
      n_fail++;
      $display("FAIL mid_reset_state got=%h exp=%h", obs_a(), ra);
    end
    tick(1'b0);
    n_checks++;
    if (obs_a() !== model(DA, t)) begin
      n_fail++;
      $display("FAIL mid_reset_resume got=%h exp=%h", obs_a(), model(DA, t));
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          tick(1'b1);
          n_checks++;
          if (obs_a() !== model(DA, t) || obs_b() !== model(DB, t)) begin
            n_fail++;
            $display("FAIL random_reset a=%h b=%h exp a=%h b=%h", obs_a(), obs_b(), model(DA, t), model(DB, t));
          end
        end
      end
      len = $urandom_range(1, 400);
      for (int j = 0; j < len; j++) begin
        tick(1'b0);
        n_checks++;
        if (obs_a() !== model(DA, t) || obs_b() !== model(DB, t)) begin
          n_fail++;
          $display("FAIL random_run t=%0d a=%h b=%h exp a=%h b=%h", t, obs_a(), obs_b(), model(DA, t), model(DB, t));
        end
      end
      $display("test_random burst %0d len=%0d t=%0d", k, len, t);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_frame_counter();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480@60 Hz VGA output. It divides the system clock down to the pixel rate and runs the horizontal and vertical counters. It drives the pixel coordinates consumed by the background and object drawing stages, and produces the sync, blanking and frame-boundary strobes used by the screen driver and the game logic. It sits directly upstream of the background colour stage, so every drawing stage sees the same (X, Y) on the same cycle.

## Interface
Parameters:
- CLK_DIV, 2, CLK cycles per pixel (system 50 MHz -> 25 MHz pixel rate); legal range 1..8
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- CLK  in  1  system clock; the only clock
- RESETn  in  1  reset, synchronous and active-high (asserted = 1, sampled on the CLK rising edge), despite the suffix
- oCoord_X  out  11  current horizontal count, 0..H_TOTAL-1
- oCoord_Y  out  11  current vertical count, 0..V_TOTAL-1
- oVGA_HS  out  1  horizontal sync, active-low
- oVGA_VS  out  1  vertical sync, active-low
- oVGA_BLANK_N  out  1  1 while (X, Y) is inside the visible area
- oPix_En  out  1  1 on the last CLK of each pixel period, when counters advance
- oFrame_End  out  1  one-CLK pulse on the final pixel of a frame
- oFrame_Cnt  out  8  frame counter, wraps 255 -> 0

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- div counter runs 0..CLK_DIV-1 and wraps. pix_tick = (div == CLK_DIV-1). With CLK_DIV=1, pix_tick is 1 on every cycle.
- On a pix_tick cycle:
  - h increments. At H_TOTAL-1, h wraps to 0 and v increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0 and oFrame_Cnt increments modulo 256.
- Outputs are decoded from the registered h/v/div state only, so there is no input-to-output combinational path:
  - oCoord_X = h, oCoord_Y = v.
  - oVGA_HS = 0 iff H_VISIBLE+H_FP <= h <= H_VISIBLE+H_FP+H_SYNC-1 (656..751).
  - oVGA_VS = 0 iff V_VISIBLE+V_FP <= v <= V_VISIBLE+V_FP+V_SYNC-1 (490..491).
  - oVGA_BLANK_N = (h < H_VISIBLE) && (v < V_VISIBLE).
  - oPix_En = pix_tick.
  - oFrame_End = pix_tick && h==H_TOTAL-1 && v==V_TOTAL-1.
- All of these outputs describe the same pixel in the same cycle. Downstream colour stages therefore need no alignment delay.
- Coordinates are held constant for all CLK_DIV cycles of a pixel.
- Width rule: counters are 11 bits. H_TOTAL and V_TOTAL must be <= 2047, enforced by an elaboration-time check.

## Timing
- Reset (RESETn=1 at a rising edge) sets div=0, h=0, v=0, oFrame_Cnt=0. From the next cycle, outputs read:
  - oCoord_X=0, oCoord_Y=0
  - oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=1
  - oPix_En = (CLK_DIV==1)
  - oFrame_End=0
- Reset mid-frame is immediate: the next cycle shows the reset values, with no completion of the current line or pulse.
- Reset held high freezes the counters at 0.
- After reset release, the first advance (to X=1) is CLK_DIV cycles later.
- Line period = 800*CLK_DIV CLK. Frame period = 420000*CLK_DIV CLK.
- HS falls exactly 656*CLK_DIV CLK after X=0 begins and stays low for 96*CLK_DIV CLK.
- VS changes only at line boundaries, together with the X 799->0 transition.
- oFrame_End is high for exactly one CLK per frame, coincident with oPix_En. oFrame_Cnt updates on the following cycle.

## Test plan
- Reset: hold RESETn=1 for 3 cycles, then release with CLK_DIV=2 -> outputs at reset values; oCoord_X steps to 1 after 2 CLK, then to 2 after 2 more.
- Horizontal timing: run 2 lines -> X sequence 0..799 then 0; HS low for X 656..751 (192 CLK); BLANK_N low for X >= 640; Y increments at X 799->0.
- Vertical timing: run a full frame -> VS low only on Y 490..491 (3200 CLK); BLANK_N low for all of Y >= 480; Y wraps 524->0.
- Frame strobe and counter: run 257 frames -> oFrame_End single-CLK pulses 840000 CLK apart; oFrame_Cnt reads 255 then wraps to 0, then reads 1.
- Reset mid-operation: assert RESETn at X=700, Y=491 (HS and VS both low) -> next cycle X=0, Y=0, HS=1, VS=1, oFrame_Cnt=0.
- CLK_DIV=1 build: oPix_En constant 1; line = 800 CLK; frame = 420000 CLK.
